spi_m_frame_seq: RTL and testbench
==================================

SPI_M_FRAME_SEQ -- requirements
Module: spi_m_frame_seq

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, frame width in bits; FIFO_DEPTH, default 4, power of two, entries per FIFO; GAP_CYCLES, default 10, idle clocks between frames (used only under SPI_SEQ_GAP_EN).
REQ-002 clk  input  1  single system clock; all logic rising-edge.
REQ-003 arstn  input  1  asynchronous active-low reset.
REQ-004 tx_wr_en  input  1  push tx_wr_data into TX FIFO.
REQ-005 tx_wr_data  input  DATA_WIDTH  word to transmit.
REQ-006 tx_full  output  1  TX FIFO holds FIFO_DEPTH words.
REQ-007 tx_wr_err  output  1  one-cycle pulse, write attempted while full.
REQ-008 rx_rd_en  input  1  pop RX FIFO.
REQ-009 rx_rd_data  output  DATA_WIDTH  RX FIFO head word, valid while rx_empty low.
REQ-010 rx_empty  output  1  RX FIFO holds no words.
REQ-011 rx_overflow  output  1  sticky: received word dropped because RX FIFO full.
REQ-012 spi_m_start  output  1  one-cycle start pulse to SPI master.
REQ-013 data_m_send  output  DATA_WIDTH  word to SPI master.
REQ-014 spi_m_done  input  1  SPI master frame-complete indication.
REQ-015 data_m_recv  input  DATA_WIDTH  word received by SPI master, valid while spi_m_done high.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, GAP.
REQ-018 IDLE with TX FIFO non-empty SHALL pop the head into the data_m_send register and go to START on the same edge.
REQ-019 START SHALL drive spi_m_start high for exactly one cycle, then go to WAIT.
REQ-020 A word written into an empty TX FIFO at edge N while IDLE SHALL produce spi_m_start high in the cycle after edge N+2.
REQ-021 data_m_send SHALL stay constant from the START cycle until leaving WAIT.
REQ-022 WAIT SHALL ignore spi_m_done until the cycle after START; the first subsequent cycle with spi_m_done high completes the frame.
REQ-023 On completion data_m_recv SHALL be pushed into the RX FIFO; if RX is full and no rx_rd_en that cycle, the word SHALL be dropped and rx_overflow set.
REQ-024 After completion the FSM SHALL go to GAP (SPI_SEQ_GAP_EN) or IDLE (without).
REQ-025 TX write while full SHALL be discarded and pulse tx_wr_err, even if a pop occurs the same cycle.
REQ-026 Simultaneous TX push and pop on non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-027 RX pop while empty SHALL be ignored; simultaneous RX push and pop on full FIFO SHALL both take effect.
REQ-028 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full = MSBs differ, low bits equal.
REQ-029 rx_rd_data SHALL be combinational from RX head; rx_overflow SHALL clear only on reset.

Reset
REQ-030 arstn low SHALL immediately force: state IDLE, both FIFOs empty, spi_m_start 0, data_m_send 0, tx_full 0, tx_wr_err 0, rx_empty 1, rx_overflow 0, busy 0, gap counter 0.
REQ-031 Reset mid-frame SHALL abandon the frame; a spi_m_done arriving after reset release while IDLE SHALL be ignored.

Configuration
REQ-032 Macro SPI_SEQ_GAP_EN defined: GAP SHALL hold for exactly GAP_CYCLES clocks (busy high), then go to IDLE; next spi_m_start no earlier than GAP_CYCLES+2 cycles after the completing spi_m_done.
REQ-033 Macro SPI_SEQ_GAP_EN undefined: GAP state and counter SHALL not exist; completion goes straight to IDLE; next spi_m_start 2 cycles after completion if TX non-empty.

Verification
REQ-034 Write 0xAB to empty TX; SPI model returns 0xEF -> spi_m_start one cycle, data_m_send 0xAB, rx_rd_data 0xEF, rx_empty 0 after done.
REQ-035 Write 0xAB, 0xEE back-to-back -> two frames in order, RX reads 0xEF then 0xAA; with SPI_SEQ_GAP_EN, start-to-previous-done spacing exactly 12 cycles (GAP_CYCLES=10).
REQ-036 Write 5 words with master stalled -> tx_full after 4th, tx_wr_err pulses on 5th, 5th word never transmitted.
REQ-037 Run 5 frames without reading RX -> 4 words retained (first four), rx_overflow 1 after 5th done.
REQ-038 Assert arstn low in WAIT after 0x55 start -> all outputs at reset values, no RX push, later spi_m_done ignored.
REQ-039 Push 9 words through with interleaved reads -> pointers wrap, data order preserved, no flag errors.

Source files
------------

// File: rtl/spi_m_frame_seq.sv
// SPI master frame sequencer (optional inter-frame gap via SPI_SEQ_GAP_EN): TX FIFO word -> one-cycle spi_m_start, 2 clocks after landing in an idle FIFO -> wait for spi_m_done -> RX FIFO.
// Backpressure: writes to a full TX FIFO are dropped with tx_wr_err; words arriving at a full RX FIFO are dropped and set sticky rx_overflow.

module spi_m_frame_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module spi_m_frame_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  tx_wr_en,
  input  logic [DATA_WIDTH-1:0] tx_wr_data,
  output logic                  tx_full,
  output logic                  tx_wr_err,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_rd_data,
  output logic                  rx_empty,
  output logic                  rx_overflow,
  output logic                  spi_m_start,
  output logic [DATA_WIDTH-1:0] data_m_send,
  input  logic                  spi_m_done,
  input  logic [DATA_WIDTH-1:0] data_m_recv,
  output logic                  busy
);
`ifdef SPI_SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
`endif

  state_t                state;
  state_t                state_nxt;
  logic                  tx_empty;
  logic                  rx_full;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_pop;
  logic                  start_set;
  logic                  frame_done;

`ifdef SPI_SEQ_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)              gap_cnt <= '0;
    else if (state != GAP)   gap_cnt <= '0;
    else                     gap_cnt <= gap_cnt + GAP_ONE;
  end
`endif

  spi_m_frame_seq_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .push    (tx_wr_en && !tx_full),
    .pop     (tx_pop),
    .wr_data (tx_wr_data),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  spi_m_frame_seq_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .push    (frame_done),
    .pop     (rx_rd_en),
    .wr_data (data_m_recv),
    .rd_data (rx_rd_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign busy = (state != IDLE);

  // The first WAIT cycle carries the start pulse; done is only honoured after it.
  always_comb begin
    state_nxt  = state;
    tx_pop     = 1'b0;
    start_set  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        start_set = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (spi_m_done && !spi_m_start) begin
          frame_done = 1'b1;
`ifdef SPI_SEQ_GAP_EN
          state_nxt  = GAP;
`else
          state_nxt  = IDLE;
`endif
        end
      end
`ifdef SPI_SEQ_GAP_EN
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      spi_m_start <= 1'b0;
      data_m_send <= '0;
      tx_wr_err   <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      spi_m_start <= start_set;
      tx_wr_err   <= tx_wr_en && tx_full;
      if (tx_pop) data_m_send <= tx_head;
      if (frame_done && rx_full && !rx_rd_en) rx_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_m_frame_seq.sv
// Scoreboard bench for spi_m_frame_seq with a responsive SPI master model (reply = sent ^ 0x44).
module tb_spi_m_frame_seq;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 10;
`ifdef SPI_SEQ_GAP_EN
  localparam int SPACING = GAP + 2;
`else
  localparam int SPACING = 2;
`endif

  logic          clk = 1'b0;
  logic          arstn;
  logic          tx_wr_en;
  logic [DW-1:0] tx_wr_data;
  logic          tx_full;
  logic          tx_wr_err;
  logic          rx_rd_en;
  logic [DW-1:0] rx_rd_data;
  logic          rx_empty;
  logic          rx_overflow;
  logic          spi_m_start;
  logic [DW-1:0] data_m_send;
  logic          spi_m_done;
  logic [DW-1:0] data_m_recv;
  logic          busy;

  spi_m_frame_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .tx_wr_en    (tx_wr_en),
    .tx_wr_data  (tx_wr_data),
    .tx_full     (tx_full),
    .tx_wr_err   (tx_wr_err),
    .rx_rd_en    (rx_rd_en),
    .rx_rd_data  (rx_rd_data),
    .rx_empty    (rx_empty),
    .rx_overflow (rx_overflow),
    .spi_m_start (spi_m_start),
    .data_m_send (data_m_send),
    .spi_m_done  (spi_m_done),
    .data_m_recv (data_m_recv),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  int start_cycs[$];
  int done_cycs[$];
  bit master_en = 1'b1;
  bit abort     = 1'b0;
  bit in_frame  = 1'b0;
  bit ovf_exp   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SPI master model: checks each start against the TX scoreboard and answers one cycle later.
  initial begin : master
    logic [DW-1:0] sent;
    spi_m_done  = 1'b0;
    data_m_recv = '0;
    forever begin
      @(negedge clk);
      if (spi_m_start) begin
        sent     = data_m_send;
        in_frame = 1'b1;
        start_cycs.push_back(cyc);
        if (tx_q.size() == 0) check("unexpected_start", data_m_send, 8'h00 ^ data_m_send ^ 8'hFF);
        else                  check("data_m_send", sent, tx_q.pop_front());
        @(negedge clk);
        check("start_one_cycle", spi_m_start, 1'b0);
        while (!master_en && !abort) @(negedge clk);
        if (!abort) begin
          check("send_stable", data_m_send, sent);
          spi_m_done  = 1'b1;
          data_m_recv = sent ^ 8'h44;
          done_cycs.push_back(cyc);
          if (rx_q.size() < DEPTH) rx_q.push_back(sent ^ 8'h44);
          else                     ovf_exp = 1'b1;
          @(negedge clk);
          spi_m_done  = 1'b0;
          data_m_recv = '0;
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic push_tx(input logic [DW-1:0] d, input bit accept);
    @(negedge clk);
    tx_wr_en   = 1'b1;
    tx_wr_data = d;
    if (accept) tx_q.push_back(d);
  endtask

  task automatic push_end();
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || in_frame || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {tx_q.size() != 0, in_frame, busy}, 3'b000);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!in_frame && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_started", in_frame, 1'b1);
  endtask

  task automatic read_rx();
    check("rx_empty_before_read", rx_empty, 1'b0);
    check("rx_rd_data", rx_rd_data, rx_q.pop_front());
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_spi_m_start"}, spi_m_start, 1'b0);
    check({p, "_data_m_send"}, data_m_send, 8'h00);
    check({p, "_tx_full"},     tx_full,     1'b0);
    check({p, "_tx_wr_err"},   tx_wr_err,   1'b0);
    check({p, "_rx_empty"},    rx_empty,    1'b1);
    check({p, "_rx_overflow"}, rx_overflow, 1'b0);
    check({p, "_busy"},        busy,        1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0;
    int wcyc;
    arstn      = 1'b0;
    tx_wr_en   = 1'b0;
    tx_wr_data = '0;
    rx_rd_en   = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    arstn = 1'b1;

    // Single frame: latency from write edge to start pulse, RX result.
    n0 = start_cycs.size();
    push_tx(8'hAB, 1'b1);
    wcyc = cyc;
    push_end();
    wait_idle();
    check("start_latency", start_cycs[n0] - wcyc - 1, 2);
    check("rx_empty_after_done", rx_empty, 1'b0);
    read_rx();
    check("rx_empty_after_read", rx_empty, 1'b1);

    // Back-to-back words: order and start-to-previous-done spacing (edges after done sample).
    n0 = start_cycs.size();
    push_tx(8'hAB, 1'b1);
    push_tx(8'hEE, 1'b1);
    push_end();
    wait_idle();
    check("frame_count", start_cycs.size() - n0, 2);
    check("start_spacing", start_cycs[n0 + 1] - done_cycs[n0] - 1, SPACING);
    read_rx();
    read_rx();

    // Stalled master: TX fills after 4 writes, 5th errors; 5 frames overflow RX.
    master_en = 1'b0;
    push_tx(8'h10, 1'b1);
    push_end();
    wait_frame();
    for (int i = 1; i <= 4; i++) push_tx(8'(8'h10 + i), 1'b1);
    push_end();
    check("tx_full_after_4", tx_full, 1'b1);
    check("tx_wr_err_quiet", tx_wr_err, 1'b0);
    push_tx(8'h15, 1'b0);
    push_end();
    check("tx_wr_err_pulse", tx_wr_err, 1'b1);
    check("tx_full_held", tx_full, 1'b1);
    @(negedge clk);
    check("tx_wr_err_one_cycle", tx_wr_err, 1'b0);
    master_en = 1'b1;
    wait_idle();
    check("rx_overflow_set", rx_overflow, ovf_exp);
    check("tx_full_drained", tx_full, 1'b0);
    while (rx_q.size() > 0) read_rx();
    check("rx_empty_drained", rx_empty, 1'b1);
    check("rx_overflow_sticky", rx_overflow, 1'b1);

    // Reset in WAIT: frame abandoned, late done ignored, empty pop ignored.
    master_en = 1'b0;
    push_tx(8'h55, 1'b1);
    push_end();
    wait_frame();
    repeat (2) @(negedge clk);
    check("busy_in_wait", busy, 1'b1);
    arstn = 1'b0;
    abort = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rx_q.delete();
    ovf_exp = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    master_en = 1'b1;
    spi_m_done  = 1'b1;
    data_m_recv = 8'h99;
    @(negedge clk);
    spi_m_done  = 1'b0;
    data_m_recv = 8'h00;
    repeat (3) @(negedge clk);
    check("late_done_busy", busy, 1'b0);
    check("late_done_rx_empty", rx_empty, 1'b1);
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
    check("empty_pop_ignored", rx_empty, 1'b1);

    // Nine words in groups of three: pointers wrap, order preserved.
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) push_tx(8'(8'h20 + g * 3 + k), 1'b1);
      push_end();
      wait_idle();
      for (int k = 0; k < 3; k++) read_rx();
    end
    check("wrap_tx_wr_err", tx_wr_err, 1'b0);
    check("wrap_rx_overflow", rx_overflow, 1'b0);
    check("wrap_tx_full", tx_full, 1'b0);
    check("wrap_rx_empty", rx_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
